// File: rtl/sha1_msg_padder.sv
// sha1_msg_padder
// Packs a 32-bit big-endian word stream into 512-bit chunks for the chunked
// SHA-1 core. It applies the standard SHA-1 padding: a 0x80 marker byte, zero
// fill, and then the 64-bit big-endian message bit length. Each finished chunk
// is presented with first/last flags and the message tag. The chunk is held
// until the core accepts it.
//
// Optional build macro: SHA1_PAD_STATS_EN adds the chunk_cnt and msg_cnt
// statistics outputs. Without the macro, those ports and their counters do not
// exist.
module sha1_msg_padder #(
  parameter int LEN_W = 64,  // bit-length counter width (16..64)
  parameter int TAG_W = 2    // message tag width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic [1:0]       in_bytes,
  input  logic [TAG_W-1:0] in_tag,
  output logic             chunk_valid,
  input  logic             chunk_ready,
  output logic [511:0]     chunk_out,
  output logic             first_chunk,
  output logic             last_chunk,
  output logic [TAG_W-1:0] tag_out
`ifdef SHA1_PAD_STATS_EN
  ,
  output logic [31:0]      chunk_cnt,
  output logic [15:0]      msg_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_FILL = 2'd0;  // accepting message words
  localparam logic [1:0] ST_PAD  = 2'd1;  // writing marker / zeros / length
  localparam logic [1:0] ST_EMIT = 2'd2;  // chunk presented, waiting for core

  localparam logic [31:0] MARKER_WORD = 32'h8000_0000;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,     state_d;
  logic [3:0]       widx_q,      widx_d;       // next buffer word to write
  logic [LEN_W-1:0] bitlen_q,    bitlen_d;     // running message length in bits
  logic [TAG_W-1:0] tag_q,       tag_d;
  logic             first_q,     first_d;      // current chunk is first of message
  logic             last_q,      last_d;       // current chunk carries length
  logic             msg_open_q,  msg_open_d;   // a message is in progress
  logic             mark_pend_q, mark_pend_d;  // marker word still to be written
  logic             mark_done_q, mark_done_d;  // marker already in the buffer
  logic             len_hi_q,    len_hi_d;     // length high word was just written
  logic             ret_pad_q,   ret_pad_d;    // padding continues after this chunk

  logic [31:0]      buf_q [16];

  // Buffer write port driven by the FSM
  logic             wr_en;
  logic [31:0]      wr_data;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             transfer;
  logic [63:0]      len64;       // length field. Bits above LEN_W are zero.
  logic [5:0]       add_bits;    // bits contributed by the accepted word
  logic [LEN_W-1:0] bitlen_base;
  logic [31:0]      last_word;   // final word with the marker merged in

  // During reset, the state register already reads FILL. Gate the ready
  // output so that nothing appears accepted while reset is held.
  assign in_ready    = (state_q == ST_FILL) && !reset;
  assign accept      = in_valid && in_ready;
  assign chunk_valid = (state_q == ST_EMIT);
  assign transfer    = chunk_valid && chunk_ready;
  assign first_chunk = first_q;
  assign last_chunk  = last_q;
  assign tag_out     = tag_q;
  assign len64       = 64'(bitlen_q);

  // Bits added to the length by the word offered on in_data
  always_comb begin
    add_bits = 6'd32;
    if (in_last && (in_bytes != 2'd0)) begin
      add_bits = {1'b0, in_bytes, 3'b000};
    end
  end

  // The length restarts on the first word of every message
  assign bitlen_base = msg_open_q ? bitlen_q : '0;

  // Replace the unused low bytes of a short final word with 0x80 and zeros
  always_comb begin
    unique case (in_bytes)
      2'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
      2'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
      2'd3:    last_word = {in_data[31:8],  8'h80};
      default: last_word = in_data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: FILL / PAD / EMIT
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first. If a path
  // leaves one of them unassigned, a latch is inferred.
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    bitlen_d    = bitlen_q;
    tag_d       = tag_q;
    first_d     = first_q;
    last_d      = last_q;
    msg_open_d  = msg_open_q;
    mark_pend_d = mark_pend_q;
    mark_done_d = mark_done_q;
    len_hi_d    = len_hi_q;
    ret_pad_d   = ret_pad_q;
    wr_en       = 1'b0;
    wr_data     = 32'h0000_0000;

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          wr_en    = 1'b1;
          bitlen_d = bitlen_base + LEN_W'(add_bits);
          if (!msg_open_q) begin
            tag_d   = in_tag;
            first_d = 1'b1;
          end
          if (!in_last) begin
            wr_data    = in_data;
            msg_open_d = 1'b1;
            if (widx_q == 4'd15) begin
              state_d   = ST_EMIT;
              ret_pad_d = 1'b0;
            end else begin
              widx_d = widx_q + 4'd1;
            end
          end else begin
            wr_data     = last_word;
            msg_open_d  = 1'b0;
            len_hi_d    = 1'b0;
            mark_pend_d = (in_bytes == 2'd0);
            mark_done_d = (in_bytes != 2'd0);
            if (widx_q == 4'd15) begin
              state_d   = ST_EMIT;
              ret_pad_d = 1'b1;
            end else begin
              state_d = ST_PAD;
              widx_d  = widx_q + 4'd1;
            end
          end
        end
      end

      ST_PAD: begin
        wr_en = 1'b1;
        if (mark_pend_q) begin
          wr_data     = MARKER_WORD;
          mark_pend_d = 1'b0;
          mark_done_d = 1'b1;
        end else if ((widx_q == 4'd14) && mark_done_q) begin
          // The marker was placed in an earlier word, so the length fits here
          wr_data  = len64[63:32];
          len_hi_d = 1'b1;
        end else if ((widx_q == 4'd15) && len_hi_q) begin
          wr_data     = len64[31:0];
          last_d      = 1'b1;
          len_hi_d    = 1'b0;
          mark_done_d = 1'b0;
        end

        if (widx_q == 4'd15) begin
          state_d   = ST_EMIT;
          // Without the length field in this chunk, another padding chunk follows
          ret_pad_d = !(len_hi_q && !mark_pend_q);
        end else begin
          widx_d = widx_q + 4'd1;
        end
      end

      ST_EMIT: begin
        if (transfer) begin
          widx_d  = 4'd0;
          first_d = 1'b0;
          last_d  = 1'b0;
          state_d = ret_pad_q ? ST_PAD : ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control register update
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together at the clock edge, with no ordering races between blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FILL;
      widx_q      <= 4'd0;
      bitlen_q    <= '0;
      tag_q       <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      msg_open_q  <= 1'b0;
      mark_pend_q <= 1'b0;
      mark_done_q <= 1'b0;
      len_hi_q    <= 1'b0;
      ret_pad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      bitlen_q    <= bitlen_d;
      tag_q       <= tag_d;
      first_q     <= first_d;
      last_q      <= last_d;
      msg_open_q  <= msg_open_d;
      mark_pend_q <= mark_pend_d;
      mark_done_q <= mark_done_d;
      len_hi_q    <= len_hi_d;
      ret_pad_q   <= ret_pad_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Chunk buffer: one word written per clock at widx
  // ---------------------------------------------------------------------------
  // NOTE: this buffer is reset even though every word is rewritten before each
  // chunk is emitted. The reason is that chunk_out must read as zero out of
  // reset, and it is wired straight from the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= 32'h0000_0000;
      end
    end else if (wr_en) begin
      buf_q[widx_q] <= wr_data;
    end
  end

  // Word 0 occupies the most significant 32 bits of the chunk
  always_comb begin
    chunk_out = '0;
    for (int i = 0; i < 16; i++) begin
      chunk_out[511 - 32*i -: 32] = buf_q[i];
    end
  end

`ifdef SHA1_PAD_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics: chunks delivered and messages completed
  // ---------------------------------------------------------------------------
  logic [31:0] chunk_cnt_q;
  logic [15:0] msg_cnt_q;

  // Count transfers. A transfer carrying the length field completes a message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chunk_cnt_q <= 32'd0;
      msg_cnt_q   <= 16'd0;
    end else if (transfer) begin
      chunk_cnt_q <= chunk_cnt_q + 32'd1;
      if (last_q) begin
        msg_cnt_q <= msg_cnt_q + 16'd1;
      end
    end
  end

  assign chunk_cnt = chunk_cnt_q;
  assign msg_cnt   = msg_cnt_q;
`endif

endmodule

// File: tb/tb_sha1_msg_padder.sv
// tb_sha1_msg_padder
// Directed and randomized checks of sha1_msg_padder. The reference model pads
// each message at byte level: message, then 0x80, zeros up to 56 mod 64, then
// the 64-bit bit length. The padded bytes are cut into 64-byte chunks.
module tb_sha1_msg_padder;

  localparam int TAG_W = 2;

  typedef struct {
    logic [511:0]     data;
    logic             first;
    logic             last;
    logic [TAG_W-1:0] tag;
  } chunk_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic [1:0]       in_bytes;
  logic [TAG_W-1:0] in_tag;
  logic             chunk_valid;
  logic             chunk_ready;
  logic [511:0]     chunk_out;
  logic             first_chunk;
  logic             last_chunk;
  logic [TAG_W-1:0] tag_out;

  int vectors     = 0;
  int miscompares = 0;

  chunk_t exp_q[$];
  chunk_t obs_q[$];
  byte unsigned msg[$];

  sha1_msg_padder #(.LEN_W(64), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .in_tag     (in_tag),
    .chunk_valid(chunk_valid),
    .chunk_ready(chunk_ready),
    .chunk_out  (chunk_out),
    .first_chunk(first_chunk),
    .last_chunk (last_chunk),
    .tag_out    (tag_out)
  );

  always #5 clk = ~clk;

  // Record each chunk transfer. Inputs change only just after posedge, so the
  // values seen at negedge are the ones the next posedge acts on.
  always @(negedge clk) begin
    if (!reset && chunk_valid && chunk_ready) begin
      obs_q.push_back('{data: chunk_out, first: first_chunk, last: last_chunk, tag: tag_out});
    end
  end

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random message body of n bytes
  task automatic make_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  // Reference model: append the expected chunks of msg to exp_q
  task automatic model_msg(input logic [TAG_W-1:0] tag);
    byte unsigned pad[$];
    logic [63:0]  bits;
    int           nchunks;
    pad  = msg;
    bits = 64'(msg.size()) * 64'd8;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
    nchunks = pad.size() / 64;
    for (int c = 0; c < nchunks; c++) begin
      chunk_t ch;
      ch.data  = '0;
      for (int b = 0; b < 64; b++) ch.data[511 - 8*b -: 8] = pad[64*c + b];
      ch.first = (c == 0);
      ch.last  = (c == nchunks - 1);
      ch.tag   = tag;
      exp_q.push_back(ch);
    end
  endtask

  // Offer one word and wait (bounded) until it is accepted
  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb,
                           input logic [TAG_W-1:0] tag);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    in_tag   = tag;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 300) begin
        check("in_ready timeout", {511'd0, in_ready}, 512'd1);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Drive msg as a word stream. Unused low bytes of the last word are random.
  task automatic drive_msg(input logic [TAG_W-1:0] tag);
    int n  = msg.size();
    int nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d;
      d = $urandom;
      for (int b = 0; b < 4; b++) begin
        if (4*w + b < n) d[31 - 8*b -: 8] = msg[4*w + b];
      end
      send_word(d, w == nw - 1, (w == nw - 1) ? 2'(n % 4) : 2'($urandom), tag);
    end
  endtask

  // Wait (bounded) for all expected chunks, then compare them field by field
  task automatic drain_and_compare(input string name);
    int waited = 0;
    while (obs_q.size() < exp_q.size() && waited < 2000) begin
      tick();
      waited++;
    end
    repeat (20) tick();
    check({name, " chunk count"}, 512'(obs_q.size()), 512'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        check($sformatf("%s c%0d data", name, i),  obs_q[i].data,  exp_q[i].data);
        check($sformatf("%s c%0d first", name, i), 512'(obs_q[i].first), 512'(exp_q[i].first));
        check($sformatf("%s c%0d last", name, i),  512'(obs_q[i].last),  512'(exp_q[i].last));
        check($sformatf("%s c%0d tag", name, i),   512'(obs_q[i].tag),   512'(exp_q[i].tag));
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic run_msg(input string name, input int n, input logic [TAG_W-1:0] tag);
    make_msg(n);
    model_msg(tag);
    drive_msg(tag);
    drain_and_compare(name);
  endtask

  // "abc" with a latency check and a comparison against the known chunk
  task automatic run_abc(input string name);
    logic [511:0] abc_exp;
    int lat = 0;
    abc_exp = {32'h6162_6380, 448'd0, 32'h0000_0018};
    obs_q.delete();
    send_word(32'h6162_6300, 1'b1, 2'd3, 2'd1);
    do begin
      @(negedge clk);
      lat++;
    end while (!chunk_valid && lat < 40);
    check({name, " latency"}, 512'(lat), 512'd16);
    tick();
    repeat (5) tick();
    check({name, " chunk count"}, 512'(obs_q.size()), 512'd1);
    if (obs_q.size() > 0) begin
      check({name, " data"},  obs_q[0].data, abc_exp);
      check({name, " first"}, 512'(obs_q[0].first), 512'd1);
      check({name, " last"},  512'(obs_q[0].last),  512'd1);
      check({name, " tag"},   512'(obs_q[0].tag),   512'd1);
    end
    obs_q.delete();
  endtask

  initial begin
    logic [511:0] held;
    int waited;

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    in_bytes    = '0;
    in_tag      = '0;
    chunk_ready = 1'b1;

    // Reset state while reset is held
    repeat (3) @(negedge clk);
    check("rst chunk_valid", 512'(chunk_valid), 512'd0);
    check("rst in_ready",    512'(in_ready),    512'd0);
    check("rst chunk_out",   chunk_out,         512'd0);
    check("rst first",       512'(first_chunk), 512'd0);
    check("rst last",        512'(last_chunk),  512'd0);
    check("rst tag",         512'(tag_out),     512'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 512'(in_ready), 512'd1);
    tick();

    // "abc" single chunk
    run_abc("abc");

    // Length boundaries around one and two chunks
    run_msg("len55", 55, 2'd0);
    run_msg("len56", 56, 2'd1);
    run_msg("len59", 59, 2'd2);
    run_msg("len60", 60, 2'd3);
    run_msg("len63", 63, 2'd0);
    run_msg("len64", 64, 2'd1);
    run_msg("len65", 65, 2'd2);

    // Random lengths and tags
    for (int k = 0; k < 10; k++) begin
      run_msg($sformatf("rand%0d", k), $urandom_range(1, 200), 2'($urandom));
    end

    // Back-to-back messages tagged 2 and 3
    make_msg(70);
    model_msg(2'd2);
    drive_msg(2'd2);
    make_msg(9);
    model_msg(2'd3);
    drive_msg(2'd3);
    drain_and_compare("b2b");

    // Backpressure: hold the chunk for 50 cycles
    chunk_ready = 1'b0;
    make_msg(20);
    model_msg(2'd1);
    drive_msg(2'd1);
    waited = 0;
    while (!chunk_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("bp valid rises", 512'(chunk_valid), 512'd1);
    held = chunk_out;
    check("bp chunk", held, exp_q[0].data);
    repeat (50) tick();
    @(negedge clk);
    check("bp valid held",  512'(chunk_valid), 512'd1);
    check("bp chunk held",  chunk_out, held);
    check("bp in_ready",    512'(in_ready), 512'd0);
    check("bp no transfer", 512'(obs_q.size()), 512'd0);
    tick();
    chunk_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp valid drops", 512'(chunk_valid), 512'd0);
    drain_and_compare("bp");

    // Reset pulsed in the middle of a message
    make_msg(28);
    for (int w = 0; w < 7; w++) begin
      send_word({msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]}, 1'b0, 2'd0, 2'd2);
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst chunk_valid", 512'(chunk_valid), 512'd0);
    check("midrst chunk_out",   chunk_out,         512'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst in_ready", 512'(in_ready), 512'd1);
    check("midrst valid",    512'(chunk_valid), 512'd0);
    tick();
    obs_q.delete();
    run_abc("abc after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
